ia_compressor: RTL and testbench

Output-side compressor for the sparse PE array. It accepts one dense output-feature vector per pixel, one channel per beat, with optional ReLU. It emits the compressed IA bundle the PE consumes on its IA inputs: packed non-zero values, their channel indices and a count. It sits between a PE's output-feature drain and the IA buffer of the next layer, and is the writer for the PE's IA reader.

---
 rtl/ia_compressor.sv | 146 ++++++++++++++
 tb/tb_ia_compressor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ia_compressor.sv
// Output-side compressor: collects one dense channel vector per pixel, applies
// optional ReLU and packs the non-zero values with their channel indices.
module ia_compressor #(
    parameter int DATA_BW = 16,
    parameter int C_BW    = 5,
    parameter int CHANNEL = 32
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_start,
    input  logic                                i_relu,
    input  logic                                i_valid,
    output logic                                o_ready,
    input  logic signed [DATA_BW-1:0]           i_data,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic [CHANNEL-1:0][DATA_BW-1:0]     o_ia_data,
    output logic [CHANNEL-1:0][C_BW-1:0]        o_ia_c_idx,
    output logic [$clog2(CHANNEL):0]            o_ia_len,
    output logic                                o_busy
);

    localparam int LEN_BW = $clog2(CHANNEL) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [C_BW-1:0]                 ch_q, ch_d;
    logic [LEN_BW-1:0]               len_q, len_d;
    logic                            relu_q, relu_d;
    logic [CHANNEL-1:0][DATA_BW-1:0] data_q, data_d;
    logic [CHANNEL-1:0][C_BW-1:0]    idx_q, idx_d;
    logic                            ready_q, ready_d;
    logic                            valid_q, valid_d;
    logic                            busy_q, busy_d;
    logic signed [DATA_BW-1:0]       beat_s;

    // Next-state, slot packing and handshake decode for the collect FSM.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        len_d   = len_q;
        relu_d  = relu_q;
        data_d  = data_q;
        idx_d   = idx_q;

        if (relu_q && i_data[DATA_BW-1]) begin
            beat_s = {DATA_BW{1'b0}};
        end else begin
            beat_s = i_data;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_COLLECT;
                    ch_d    = {C_BW{1'b0}};
                    len_d   = {LEN_BW{1'b0}};
                    relu_d  = i_relu;
                    data_d  = '0;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (i_valid) begin
                    // Zeros still consume a channel index but take no slot.
                    if (beat_s != {DATA_BW{1'b0}}) begin
                        for (int k = 0; k < CHANNEL; k++) begin
                            if (LEN_BW'(k) == len_q) begin
                                data_d[k] = beat_s;
                                idx_d[k]  = ch_q;
                            end else begin
                                data_d[k] = data_q[k];
                                idx_d[k]  = idx_q[k];
                            end
                        end
                        len_d = len_q + LEN_BW'(1);
                    end else begin
                        len_d = len_q;
                    end
                    ch_d = ch_q + C_BW'(1);
                    if (ch_q == C_BW'(CHANNEL - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_COLLECT);
        valid_d = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    // State, bundle and handshake registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ch_q    <= {C_BW{1'b0}};
            len_q   <= {LEN_BW{1'b0}};
            relu_q  <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            len_q   <= len_d;
            relu_q  <= relu_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_busy     = busy_q;
    assign o_ia_len   = len_q;
    assign o_ia_data  = data_q;
    assign o_ia_c_idx = idx_q;

endmodule

// File: tb/tb_ia_compressor.sv
// Directed bench for ia_compressor: packing, ReLU, extremes, backpressure,
// gaps, ignored starts and reset in COLLECT/DONE.
module tb_ia_compressor;

    localparam int DW = 16;
    localparam int CW = 5;
    localparam int CH = 32;
    localparam int LW = 6;

    logic                     clk = 1'b0;
    logic                     rst, start, relu, valid_in, ready_in;
    logic                     ready_out, valid_out, busy;
    logic signed [DW-1:0]     data_in;
    logic [CH-1:0][DW-1:0]    ia_data;
    logic [CH-1:0][CW-1:0]    ia_idx;
    logic [LW-1:0]            ia_len;

    ia_compressor #(.DATA_BW(DW), .C_BW(CW), .CHANNEL(CH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_relu     (relu),
        .i_valid    (valid_in),
        .o_ready    (ready_out),
        .i_data     (data_in),
        .o_valid    (valid_out),
        .i_ready    (ready_in),
        .o_ia_data  (ia_data),
        .o_ia_c_idx (ia_idx),
        .o_ia_len   (ia_len),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic signed [DW-1:0] vec [CH];
    int exp_d [CH];
    int exp_i [CH];
    int exp_len;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_vec();
        for (int c = 0; c < CH; c++) vec[c] = 16'sd0;
    endtask

    // Expected packing of vec: non-zero survivors in channel order.
    task automatic model(input bit r);
        exp_len = 0;
        for (int c = 0; c < CH; c++) begin
            exp_d[c] = 0;
            exp_i[c] = 0;
        end
        for (int c = 0; c < CH; c++) begin
            int v;
            v = int'(vec[c]);
            if (r && v < 0) v = 0;
            if (v != 0) begin
                exp_d[exp_len] = v;
                exp_i[exp_len] = c;
                exp_len++;
            end
        end
    endtask

    task automatic check_bundle(input string tag);
        check_eq({tag, "_len"}, int'(ia_len), exp_len);
        for (int k = 0; k < CH; k++) begin
            check_eq($sformatf("%s_d%0d", tag, k), int'($signed(ia_data[k])), exp_d[k]);
            check_eq($sformatf("%s_i%0d", tag, k), int'(ia_idx[k]), exp_i[k]);
        end
    endtask

    task automatic check_slot(input string tag, input int k, input int d, input int i);
        check_eq($sformatf("%s_data%0d", tag, k), int'($signed(ia_data[k])), d);
        check_eq($sformatf("%s_idx%0d", tag, k), int'(ia_idx[k]), i);
    endtask

    task automatic run_vec(input string tag, input bit r, input bit gaps,
                           input int hold, input bit rst_in_done);
        int start_cyc;
        int t;
        // A beat offered together with start must not be taken.
        start    = 1'b1;
        relu     = r;
        valid_in = 1'b1;
        data_in  = 16'sd99;
        tick();
        start_cyc = cyc;
        start     = 1'b0;
        valid_in  = 1'b0;
        check_eq({tag, "_ready_collect"}, int'(ready_out), 1);
        for (int c = 0; c < CH; c++) begin
            if (gaps) begin
                int n;
                n = (c == 5) ? 1 : int'($urandom_range(0, 2));
                for (int g = 0; g < n; g++) begin
                    valid_in = 1'b0;
                    start    = (c == 5);
                    tick();
                    start = 1'b0;
                    if (c == 5) check_eq({tag, "_busy_start_ign"}, int'(busy), 1);
                end
            end
            valid_in = 1'b1;
            data_in  = vec[c];
            tick();
        end
        valid_in = 1'b0;
        @(negedge clk);
        t = 0;
        while (valid_out !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_valid"}, int'(valid_out), 1);
        // Cycle numbering: the cycle after the start edge is cycle 1.
        if (!gaps) check_eq({tag, "_latency"}, cyc - start_cyc + 1, CH + 1);
        check_eq({tag, "_ready_done"}, int'(ready_out), 0);
        model(r);
        check_bundle(tag);
        for (int h = 0; h < hold; h++) begin
            start = (h == 1);
            tick();
            start = 1'b0;
            @(negedge clk);
            check_eq($sformatf("%s_hold_valid%0d", tag, h), int'(valid_out), 1);
            check_eq($sformatf("%s_hold_len%0d", tag, h), int'(ia_len), exp_len);
            check_eq($sformatf("%s_hold_d0_%0d", tag, h), int'($signed(ia_data[0])), exp_d[0]);
        end
        if (rst_in_done) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            @(negedge clk);
            check_eq({tag, "_rst_valid"}, int'(valid_out), 0);
            check_eq({tag, "_rst_len"}, int'(ia_len), 0);
        end else begin
            ready_in = 1'b1;
            tick();
            ready_in = 1'b0;
            @(negedge clk);
            check_eq({tag, "_post_valid"}, int'(valid_out), 0);
            check_eq({tag, "_post_busy"}, int'(busy), 0);
            check_eq({tag, "_post_len"}, int'(ia_len), exp_len);
        end
    endtask

    task automatic load_basic();
        clear_vec();
        vec[2] = 16'sd2;
        vec[3] = 16'sd3;
        vec[5] = 16'sd5;
        vec[6] = 16'sd6;
    endtask

    task automatic check_basic(input string tag);
        check_eq({tag, "_hlen"}, int'(ia_len), 4);
        check_slot(tag, 0, 2, 2);
        check_slot(tag, 1, 3, 3);
        check_slot(tag, 2, 5, 5);
        check_slot(tag, 3, 6, 6);
        check_slot(tag, 4, 0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; relu = 1'b0; valid_in = 1'b0;
        ready_in = 1'b0; data_in = 16'sd0;
        clear_vec();
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", int'(ready_out), 0);
        check_eq("rst_valid", int'(valid_out), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_len", int'(ia_len), 0);
        check_eq("rst_d0", int'($signed(ia_data[0])), 0);

        // Reset has priority over a simultaneous start.
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check_eq("rst_start_busy", int'(busy), 0);
        check_eq("rst_start_ready", int'(ready_out), 0);

        load_basic();
        run_vec("basic", 1'b0, 1'b0, 0, 1'b0);
        check_basic("basic_hand");

        clear_vec();
        vec[0] = -16'sd7; vec[1] = 16'sd4; vec[30] = 16'sd9; vec[31] = -16'sd1;
        run_vec("relu1", 1'b1, 1'b0, 0, 1'b0);
        check_eq("relu1_hlen", int'(ia_len), 2);
        check_slot("relu1_hand", 0, 4, 1);
        check_slot("relu1_hand", 1, 9, 30);

        run_vec("relu0", 1'b0, 1'b0, 0, 1'b0);
        check_eq("relu0_hlen", int'(ia_len), 4);
        check_slot("relu0_hand", 0, -7, 0);
        check_slot("relu0_hand", 1, 4, 1);
        check_slot("relu0_hand", 2, 9, 30);
        check_slot("relu0_hand", 3, -1, 31);

        clear_vec();
        run_vec("zero", 1'b0, 1'b0, 0, 1'b0);
        check_eq("zero_hlen", int'(ia_len), 0);

        for (int c = 0; c < CH; c++) vec[c] = 16'sd1;
        run_vec("ones", 1'b1, 1'b0, 0, 1'b0);
        check_eq("ones_hlen", int'(ia_len), 32);
        check_slot("ones_hand", 31, 1, 31);

        clear_vec();
        vec[31] = 16'h8000;
        run_vec("minval", 1'b0, 1'b0, 0, 1'b0);
        check_eq("minval_hlen", int'(ia_len), 1);
        check_slot("minval_hand", 0, -32768, 31);

        load_basic();
        run_vec("gaps", 1'b0, 1'b1, 5, 1'b0);
        check_basic("gaps_hand");

        // Abort a vector after 10 beats, then verify a clean restart.
        start = 1'b1; relu = 1'b0;
        tick();
        start = 1'b0;
        for (int b = 0; b < 10; b++) begin
            valid_in = 1'b1;
            data_in  = 16'sd3;
            tick();
        end
        valid_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_ready", int'(ready_out), 0);
        check_eq("abort_valid", int'(valid_out), 0);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_len", int'(ia_len), 0);
        check_slot("abort", 1, 0, 0);
        load_basic();
        run_vec("fresh", 1'b0, 1'b0, 0, 1'b0);
        check_basic("fresh_hand");

        run_vec("rstdone", 1'b0, 1'b0, 2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
